// File: rtl/dmem_access_ctrl.sv
// MEM-stage data-memory sequencer: word accesses directly, sub-word stores as
// read-modify-write, sub-word loads extracted and extended, one stall per 2-cycle op.
module dmem_access_ctrl #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        MemWrite,
  input  logic              req_load,
  input  logic [2:0]        ld_type,
  input  logic [31:0]       addr,
  input  logic [31:0]       wdata,
  output logic              stall,
  output logic [31:0]       rdata,
  output logic              rdata_valid,
  output logic              err_misaligned,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] LD_WAIT  = 2'd1;
  localparam logic [1:0] RMW_WAIT = 2'd2;

  localparam logic [1:0] ST_SW = 2'b01;
  localparam logic [1:0] ST_SH = 2'b10;

  localparam logic [2:0] LD_LW  = 3'b001;
  localparam logic [2:0] LD_LB  = 3'b010;
  localparam logic [2:0] LD_LH  = 3'b011;
  localparam logic [2:0] LD_LBU = 3'b100;
  localparam logic [2:0] LD_LHU = 3'b101;

  logic [1:0]        state, state_nxt;
  logic [1:0]        lat_off;
  logic [2:0]        lat_ld;
  logic [15:0]       lat_sdata;
  logic              lat_half;
  logic [ADDR_W-1:0] lat_waddr;

  logic st_req, ld_req, misaligned;
  logic unused_addr_hi;

  assign unused_addr_hi = ^addr[31:ADDR_W+2];

  function automatic logic [31:0] load_extend(input logic [31:0] word,
                                              input logic [1:0]  off,
                                              input logic [2:0]  lt);
    logic signed [7:0]  sbyte;
    logic signed [15:0] shalf;
    logic signed [31:0] ext;
    sbyte = word[{off, 3'b000} +: 8];
    shalf = off[1] ? word[31:16] : word[15:0];
    ext   = '0;
    case (lt)
      LD_LB:   ext = sbyte;
      LD_LH:   ext = shalf;
      LD_LBU:  ext = {24'd0, sbyte};
      LD_LHU:  ext = {16'd0, shalf};
      default: ext = word;
    endcase
    return ext;
  endfunction

  function automatic logic [31:0] store_merge(input logic [31:0] word,
                                              input logic [15:0] data,
                                              input logic [1:0]  off,
                                              input logic        half);
    logic [31:0] merged;
    merged = word;
    if (half) merged[{off[1], 4'b0000} +: 16] = data;
    else      merged[{off, 3'b000} +: 8]      = data[7:0];
    return merged;
  endfunction

  always_comb begin
    state_nxt      = state;
    stall          = 1'b0;
    rdata          = '0;
    rdata_valid    = 1'b0;
    err_misaligned = 1'b0;
    mem_en         = 1'b0;
    mem_we         = 1'b0;
    mem_addr       = '0;
    mem_wdata      = '0;
    st_req         = (MemWrite != 2'b00);
    ld_req         = req_load && (ld_type >= LD_LW) && (ld_type <= LD_LHU);
    misaligned     = 1'b0;
    case (state)
      IDLE: begin
        // Stores win over loads when the decoder flags both.
        if (st_req)
          misaligned = ((MemWrite == ST_SW) && (addr[1:0] != 2'b00)) ||
                       ((MemWrite == ST_SH) && addr[0]);
        else if (ld_req)
          misaligned = ((ld_type == LD_LW) && (addr[1:0] != 2'b00)) ||
                       (((ld_type == LD_LH) || (ld_type == LD_LHU)) && addr[0]);
        err_misaligned = misaligned;
        if (!misaligned && (st_req || ld_req)) begin
          mem_en   = 1'b1;
          mem_addr = addr[ADDR_W+1:2];
          if (st_req && (MemWrite == ST_SW)) begin
            mem_we    = 1'b1;
            mem_wdata = wdata;
          end else begin
            stall     = 1'b1;
            state_nxt = st_req ? RMW_WAIT : LD_WAIT;
          end
        end
      end
      LD_WAIT: begin
        rdata_valid = 1'b1;
        rdata       = load_extend(mem_rdata, lat_off, lat_ld);
        state_nxt   = IDLE;
      end
      RMW_WAIT: begin
        mem_en    = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = lat_waddr;
        mem_wdata = store_merge(mem_rdata, lat_sdata, lat_off, lat_half);
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Request fields are captured only on the IDLE -> WAIT transition.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      lat_off   <= '0;
      lat_ld    <= '0;
      lat_sdata <= '0;
      lat_half  <= 1'b0;
      lat_waddr <= '0;
    end else begin
      state <= state_nxt;
      if ((state == IDLE) && (state_nxt != IDLE)) begin
        lat_off   <= addr[1:0];
        lat_ld    <= ld_type;
        lat_sdata <= wdata[15:0];
        lat_half  <= (MemWrite == ST_SH);
        lat_waddr <= addr[ADDR_W+1:2];
      end
    end
  end

endmodule

// File: doc/dmem_access_ctrl.md
Name: dmem_access_ctrl

Overview:
- Sequences MEM-stage data-memory accesses for the 32-bit pipelined core against a single-port, word-wide, 1-cycle-read-latency data RAM with no byte enables.
- Performs word accesses directly, and sub-word stores (sb/sh) as read-modify-write.
- Extracts and sign- or zero-extends sub-word loads (lb/lh/lbu/lhu).
- Asserts a one-cycle pipeline stall for every two-cycle operation.

Parameters:
- ADDR_W, 10, word-address width of data RAM (RAM depth = 2^ADDR_W words).

Ports:
- clk  in  1  core clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- MemWrite  in  2  store type from decoder: 00 none, 01 sw, 10 sh, 11 sb.
- req_load  in  1  MEM-stage instruction is a load (ResultSrc==01).
- ld_type  in  3  load type from decoder RegWrite code: 001 lw, 010 lb, 011 lh, 100 lbu, 101 lhu.
- addr  in  32  byte address from ALU.
- wdata  in  32  store data (rs2).
- stall  out  1  hold IF/ID/EX/MEM registers this cycle.
- rdata  out  32  extended load result.
- rdata_valid  out  1  rdata valid this cycle.
- err_misaligned  out  1  one-cycle pulse on a misaligned request.
- mem_en  out  1  RAM access enable.
- mem_we  out  1  RAM write enable (qualified by mem_en).
- mem_addr  out  ADDR_W  RAM word address = addr[ADDR_W+1:2]; higher bits ignored (wrap).
- mem_wdata  out  32  RAM write data.
- mem_rdata  in  32  RAM read data, valid the cycle after a read enable.

Behaviour:
- States: IDLE, LD_WAIT, RMW_WAIT. The block latches addr[1:0], ld_type and the store byte/half on leaving IDLE.
- Reset (async, rst=0): state IDLE; latched fields 0. With no request present, all outputs are 0 (stall, rdata, rdata_valid, err_misaligned, mem_en, mem_we, mem_addr, mem_wdata).
- Misaligned requests:
  - lw/sw with addr[1:0]!=0, or lh/lhu/sh with addr[0]=1.
  - Response: err_misaligned=1 combinationally in IDLE, no RAM access, no stall, stay IDLE.
- Request priority: MemWrite!=00 takes precedence over req_load if both are set.
- IDLE, sw (aligned): mem_en=1, mem_we=1, mem_wdata=wdata. Single cycle, no stall, stay IDLE.
- IDLE, sb/sh (aligned):
  - Issue read: mem_en=1, mem_we=0.
  - stall=1 combinationally, same cycle.
  - Next state RMW_WAIT.
- RMW_WAIT:
  - Merge latched byte into lane addr[1:0], or latched half into lane addr[1] (upper half if 1).
  - Remaining lanes come from mem_rdata.
  - Write: mem_en=1, mem_we=1, same mem_addr. stall=0. Next state IDLE.
- IDLE, load (aligned): issue read, stall=1, next state LD_WAIT.
- LD_WAIT:
  - Select lane per latched addr[1:0]/ld_type. lb/lh sign-extend; lbu/lhu zero-extend; lw passes through.
  - rdata_valid=1 and rdata driven, both combinational from mem_rdata this cycle. stall=0. Next state IDLE.
- Latency: sw = 1 cycle. Loads, sb and sh = 2 cycles with exactly one stall cycle.
- In WAIT states the inputs are ignored. The pipeline holds the same instruction there because stall was 1 the cycle before, so no double issue.
- Invalid ld_type (000,110,111) with req_load=1: treated as no request; no access, no stall, no error.
- Reset asserted mid-RMW: state goes to IDLE and the pending write is never issued; RAM is left holding its old value.
- rdata and mem_wdata are 0 whenever rdata_valid or mem_we, respectively, is 0.

Test Plan:
- Reset and sw:
  - Stimulus: rst=0 then release; MemWrite=01, addr=0x0000_0010, wdata=0xDEADBEEF.
  - Required: same cycle mem_en=1, mem_we=1, mem_addr=4, mem_wdata=0xDEADBEEF, stall=0.
- lb sign-extend:
  - Stimulus: RAM word 4=0x11_80_33_44; req_load=1, ld_type=010, addr=0x12.
  - Required: cycle0 stall=1 with read issued; cycle1 rdata_valid=1, rdata=0xFFFF_FF80, stall=0.
- lhu zero-extend:
  - Stimulus: same word; ld_type=101, addr=0x12.
  - Required: cycle1 rdata=0x0000_1180.
- sb read-modify-write:
  - Stimulus: RAM word 4=0xAABBCCDD; MemWrite=11, addr=0x11, wdata=0x000000EE.
  - Required: cycle0 read with stall=1; cycle1 write mem_wdata=0xAABBEEDD.
  - Follow-up: then lw from 0x10 returns 0xAABBEEDD.
- Misaligned requests:
  - Stimulus: lw at 0x13, then sh at 0x11.
  - Required: each gives err_misaligned=1 for one cycle, mem_en=0, stall=0.
- Reset mid-operation:
  - Stimulus: sh at 0x12 with wdata=0x1234; assert rst during RMW_WAIT.
  - Required: no write issued; after release state is IDLE and RAM word unchanged.
